multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states, and waits on memory through a ready handshake with a timeout. It adds conditional branch (BEQ), HALT, illegal-opcode detection and a retired-instruction counter. It sits between the instruction register/memory interface and the datapath (PC, register file, ALU).

Parameters:
OPCODE_W, 4, opcode width; the defined opcodes occupy the low 4 bits and the upper bits must be 0 for a match.
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in FETCH or MEM before aborting (>=2).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
opcode  input  OPCODE_W  opcode field from the instruction register, sampled in DECODE
mem_ready  input  1  memory completes the current read/write this cycle
zero  input  1  ALU zero flag, valid in EXECUTE
pc_write  output  1  PC load enable
ir_write  output  1  instruction-register load enable
inst_fetch  output  1  memory address source = PC (1) or ALU result (0)
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write enable
alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
alu_src  output  1  ALU B operand = immediate
jump  output  1  PC source = jump target
branch_taken  output  1  PC source = branch target
halted  output  1  core is in HALT
illegal_op  output  1  one-cycle pulse, undefined opcode decoded
bus_error  output  1  one-cycle pulse, memory timeout
retired  output  CNT_W  count of completed instructions, saturating

Behaviour:
- Reset is synchronous and active-high. While rst=1: state<=FETCH, timeout counter<=0, latched opcode<=0, retired<=0. All outputs are forced to 0 during the rst cycle.
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 LOAD, 0101 STORE, 0110 JUMP, 0111 BEQ, 1111 HALT. Every other value is illegal.
- FETCH: inst_fetch=1, mem_read=1. If mem_ready=1, assert ir_write=1 and pc_write=1 (PC+1) in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: latch opcode; no strobes.
  - Illegal opcode: pulse illegal_op, retire nothing, go to FETCH.
  - HALT: go to HALT.
  - All other opcodes: go to EXECUTE.
- EXECUTE (uses the latched opcode):
  - ALU ops: alu_op set per opcode; go to WRITEBACK.
  - LOAD/STORE: alu_op=00, alu_src=1; go to MEM.
  - JUMP: jump=1, pc_write=1; retire; go to FETCH.
  - BEQ: alu_op=01. If zero=1, assert branch_taken=1 and pc_write=1. Retire and go to FETCH in either case.
- MEM: alu_src=1 held.
  - LOAD: mem_read=1 until mem_ready, then go to WRITEBACK.
  - STORE: mem_write=1 until mem_ready, then retire and go to FETCH.
- WRITEBACK: reg_write=1 for exactly one cycle. For ALU ops alu_op is held. Retire; go to FETCH.
- HALT: halted=1, all strobes 0, stay until reset.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0.
  - When it reaches MEM_TIMEOUT-1 with mem_ready still 0, pulse bus_error and go to FETCH.
  - A timed-out instruction is not retired. A timeout in FETCH leaves the PC unchanged, so the fetch is retried.
  - mem_ready=1 in the same cycle the counter reaches the limit counts as success; bus_error is not pulsed.
- Latency with mem_ready held 1:
  - ALU op: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JUMP/BEQ: 3 cycles.
- retired increments by 1 on each retirement and saturates at all-ones.
- Strobes are never asserted together in conflicting combinations: mem_read and mem_write are never both 1; jump and branch_taken are never both 1.
- mem_ready outside FETCH and MEM is ignored.

Test Plan:
- Reset, then ADD (0000) with mem_ready=1 -> FETCH/DECODE/EXECUTE/WRITEBACK. reg_write=1 only in cycle 4 with alu_op=00. retired=1 after the 4th cycle.
- LOAD (0100) with mem_ready low for 3 MEM cycles -> mem_read held 4 cycles in MEM with alu_src=1, then reg_write pulse. retired=1. No bus_error.
- BEQ (0111) with zero=1, then again with zero=0 -> first: branch_taken=1 and pc_write=1 in EXECUTE; second: both 0. retired=2.
- Opcode 1010 -> illegal_op single pulse in DECODE, back to FETCH next cycle. retired unchanged.
- STORE with mem_ready held 0, MEM_TIMEOUT=16 -> bus_error pulse after 16 MEM cycles, mem_write never 1 after abort. retired unchanged. Repeat with mem_ready=1 on exactly the 16th cycle -> no bus_error, retired+1.
- HALT (1111) -> halted=1 and all strobes 0 indefinitely. Assert rst for 1 cycle mid-HALT, and also mid-MEM -> next cycle state is FETCH, all outputs 0 during rst, retired=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// with a bounded memory handshake, conditional branch, HALT, illegal-opcode trap and a retire counter.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_write,
  output logic                ir_write,
  output logic                inst_fetch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                jump,
  output logic                branch_taken,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [CNT_W-1:0]    retired
);

  localparam int            TW      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LIMIT = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    K_ADD,
    K_SUB,
    K_AND,
    K_OR,
    K_LOAD,
    K_STORE,
    K_JUMP,
    K_BEQ,
    K_HALT,
    K_ILLEGAL
  } op_kind_t;

  // Any set bit above the low nibble makes the opcode illegal.
  function automatic op_kind_t classify(input logic [OPCODE_W-1:0] op);
    op_kind_t k;
    k = K_ILLEGAL;
    if ((op >> 4) == '0) begin
      case (op[3:0])
        4'h0:    k = K_ADD;
        4'h1:    k = K_SUB;
        4'h2:    k = K_AND;
        4'h3:    k = K_OR;
        4'h4:    k = K_LOAD;
        4'h5:    k = K_STORE;
        4'h6:    k = K_JUMP;
        4'h7:    k = K_BEQ;
        4'hF:    k = K_HALT;
        default: k = K_ILLEGAL;
      endcase
    end
    return k;
  endfunction

  function automatic logic [1:0] alu_code(input op_kind_t k);
    logic [1:0] c;
    case (k)
      K_SUB:   c = 2'b01;
      K_AND:   c = 2'b10;
      K_OR:    c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  state_t              r_state;
  logic [OPCODE_W-1:0] r_opcode;
  logic [TW-1:0]       r_tcnt;
  logic [CNT_W-1:0]    r_retired;

  state_t   w_state_next;
  op_kind_t w_dec_kind;
  op_kind_t w_exe_kind;
  logic     w_mem_timeout;
  logic     w_tcnt_inc;
  logic     w_retire;
  logic     w_pc_write;
  logic     w_ir_write;
  logic     w_inst_fetch;
  logic     w_mem_read;
  logic     w_mem_write;
  logic     w_reg_write;
  logic [1:0] w_alu_op;
  logic     w_alu_src;
  logic     w_jump;
  logic     w_branch_taken;
  logic     w_halted;
  logic     w_illegal_op;
  logic     w_bus_error;

  assign w_dec_kind    = classify(opcode);
  assign w_exe_kind    = classify(r_opcode);
  assign w_mem_timeout = (r_tcnt == T_LIMIT) && !mem_ready;
  // Counter runs only while waiting; any other cycle clears it, so it is zero on entry to FETCH/MEM.
  assign w_tcnt_inc    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready && !w_mem_timeout;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode  <= '0;
      r_tcnt    <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
      end
      if (w_tcnt_inc) begin
        r_tcnt <= r_tcnt + 1'b1;
      end else begin
        r_tcnt <= '0;
      end
      if (w_retire && (r_retired != '1)) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_retire       = 1'b0;
    w_pc_write     = 1'b0;
    w_ir_write     = 1'b0;
    w_inst_fetch   = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_reg_write    = 1'b0;
    w_alu_op       = 2'b00;
    w_alu_src      = 1'b0;
    w_jump         = 1'b0;
    w_branch_taken = 1'b0;
    w_halted       = 1'b0;
    w_illegal_op   = 1'b0;
    w_bus_error    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_inst_fetch = 1'b1;
        w_mem_read   = 1'b1;
        if (mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_mem_timeout) begin
          // PC untouched, so the same fetch is retried.
          w_bus_error  = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_DECODE: begin
        case (w_dec_kind)
          K_ILLEGAL: begin
            w_illegal_op = 1'b1;
            w_state_next = S_FETCH;
          end
          K_HALT:  w_state_next = S_HALT;
          default: w_state_next = S_EXECUTE;
        endcase
      end

      S_EXECUTE: begin
        case (w_exe_kind)
          K_ADD, K_SUB, K_AND, K_OR: begin
            w_alu_op     = alu_code(w_exe_kind);
            w_state_next = S_WRITEBACK;
          end
          K_LOAD, K_STORE: begin
            w_alu_src    = 1'b1;
            w_state_next = S_MEM;
          end
          K_JUMP: begin
            w_jump       = 1'b1;
            w_pc_write   = 1'b1;
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end
          K_BEQ: begin
            w_alu_op       = 2'b01;
            w_branch_taken = zero;
            w_pc_write     = zero;
            w_retire       = 1'b1;
            w_state_next   = S_FETCH;
          end
          default: w_state_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        w_alu_src = 1'b1;
        if (w_exe_kind == K_STORE) begin
          w_mem_write = 1'b1;
        end else begin
          w_mem_read = 1'b1;
        end
        if (mem_ready) begin
          if (w_exe_kind == K_STORE) begin
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WRITEBACK;
          end
        end else if (w_mem_timeout) begin
          w_bus_error  = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_alu_op     = alu_code(w_exe_kind);
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_HALT: begin
        w_halted     = 1'b1;
        w_state_next = S_HALT;
      end

      default: w_state_next = S_FETCH;
    endcase
  end

  // Every output reads as zero during the reset cycle, whatever state precedes it.
  assign pc_write     = w_pc_write     & ~rst;
  assign ir_write     = w_ir_write     & ~rst;
  assign inst_fetch   = w_inst_fetch   & ~rst;
  assign mem_read     = w_mem_read     & ~rst;
  assign mem_write    = w_mem_write    & ~rst;
  assign reg_write    = w_reg_write    & ~rst;
  assign alu_op       = rst ? 2'b00 : w_alu_op;
  assign alu_src      = w_alu_src      & ~rst;
  assign jump         = w_jump         & ~rst;
  assign branch_taken = w_branch_taken & ~rst;
  assign halted       = w_halted       & ~rst;
  assign illegal_op   = w_illegal_op   & ~rst;
  assign bus_error    = w_bus_error    & ~rst;
  assign retired      = rst ? '0 : r_retired;

  a_rw_exclusive: assert property (@(posedge clk) !(mem_read && mem_write));
  a_pc_src_exclusive: assert property (@(posedge clk) !(jump && branch_taken));

endmodule
